// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - truth-table response checker for two-input gate DUTs
module gate_response_checker #(
    parameter logic [3:0] TRUTH = 4'b0001,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             smp_valid,
    input  logic             smp_a,
    input  logic             smp_b,
    input  logic             smp_y,
    output logic             smp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [3:0]       cov,
    output logic             fail_valid,
    output logic [2:0]       fail_vec
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic             accept;
    logic [1:0]       idx;
    logic             mismatch;
    logic [3:0]       cov_next;
    logic [CNT_W-1:0] smp_cnt_next;
    logic [CNT_W-1:0] err_cnt_next;

    // A sample arriving with start belongs to the run being abandoned, so it is dropped.
    assign accept       = smp_valid && smp_ready && !start;
    assign idx          = {smp_a, smp_b};
    assign mismatch     = (smp_y != TRUTH[idx]);
    assign cov_next     = cov | (4'b0001 << idx);
    assign smp_cnt_next = (smp_cnt == CNT_MAX) ? smp_cnt : smp_cnt + CNT_ONE;
    assign err_cnt_next = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_ONE;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == '0) && (cov == 4'b1111);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            smp_ready  <= 1'b0;
            err_cnt    <= '0;
            smp_cnt    <= '0;
            cov        <= 4'b0000;
            fail_valid <= 1'b0;
            fail_vec   <= 3'b000;
        end else if (start) begin
            state      <= S_RUN;
            smp_ready  <= 1'b1;
            err_cnt    <= '0;
            smp_cnt    <= '0;
            cov        <= 4'b0000;
            fail_valid <= 1'b0;
            fail_vec   <= 3'b000;
        end else if (accept) begin
            smp_cnt <= smp_cnt_next;
            cov     <= cov_next;
            if (mismatch) begin
                err_cnt <= err_cnt_next;
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_vec   <= {smp_a, smp_b, smp_y};
                end
            end
            // Finish on full coverage or when the sample counter can no longer advance.
            if ((cov_next == 4'b1111) || (smp_cnt_next == CNT_MAX)) begin
                state     <= S_DONE;
                smp_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - scoreboard bench for gate_response_checker
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic smp_valid = 1'b0;
    logic smp_a = 1'b0;
    logic smp_b = 1'b0;
    logic smp_y = 1'b0;

    logic       n_ready, n_busy, n_done, n_pass, n_fv;
    logic [7:0] n_err, n_cnt;
    logic [3:0] n_cov;
    logic [2:0] n_fvec;

    logic       s_ready, s_busy, s_done, s_pass, s_fv;
    logic [2:0] s_err, s_cnt;
    logic [3:0] s_cov;
    logic [2:0] s_fvec;

    logic       x_ready, x_busy, x_done, x_pass, x_fv;
    logic [7:0] x_err, x_cnt;
    logic [3:0] x_cov;
    logic [2:0] x_fvec;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gate_response_checker dut_nor (
        .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
        .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
        .smp_ready(n_ready), .busy(n_busy), .done(n_done), .pass(n_pass),
        .err_cnt(n_err), .smp_cnt(n_cnt), .cov(n_cov),
        .fail_valid(n_fv), .fail_vec(n_fvec)
    );

    gate_response_checker #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
        .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
        .smp_ready(s_ready), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_cnt(s_err), .smp_cnt(s_cnt), .cov(s_cov),
        .fail_valid(s_fv), .fail_vec(s_fvec)
    );

    gate_response_checker #(.TRUTH(4'b0110)) dut_xor (
        .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
        .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
        .smp_ready(x_ready), .busy(x_busy), .done(x_done), .pass(x_pass),
        .err_cnt(x_err), .smp_cnt(x_cnt), .cov(x_cov),
        .fail_valid(x_fv), .fail_vec(x_fvec)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] err;
        logic [3:0] cov;
        logic       fv;
        logic [2:0] fvec;
        logic       done;
        logic       pass;
        logic       ready;
    } exp_t;

    exp_t sb[$];

    // Reference model of the NOR instance, written from the truth table.
    logic       m_run = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    logic [7:0] m_err = 8'd0;
    logic [3:0] m_cov = 4'd0;
    logic       m_fv = 1'b0;
    logic [2:0] m_fvec = 3'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_cnt = 8'd0; m_err = 8'd0; m_cov = 4'd0; m_fv = 1'b0; m_fvec = 3'd0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic rs, input logic st, input logic v,
                              input logic a, input logic b, input logic y);
        logic exp_y;
        if (rs) begin
            model_clear();
            m_run = 1'b0;
        end else if (st) begin
            model_clear();
            m_run = 1'b1;
        end else if (v && m_run) begin
            exp_y = ~(a | b);
            if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
            m_cov[{a, b}] = 1'b1;
            if (y != exp_y) begin
                if (m_err != 8'hff) m_err = m_err + 8'd1;
                if (!m_fv) begin
                    m_fv = 1'b1;
                    m_fvec = {a, b, y};
                end
            end
            if (m_cov == 4'b1111 || m_cnt == 8'hff) begin
                m_run = 1'b0;
                m_done = 1'b1;
            end
        end
        sb.push_back('{cnt: m_cnt, err: m_err, cov: m_cov, fv: m_fv, fvec: m_fvec,
                       done: m_done, pass: m_done && m_err == 8'd0 && m_cov == 4'b1111,
                       ready: m_run});
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
            return;
        end
        total--;
        e = sb.pop_front();
        chk({tag, "_cnt"}, 32'(n_cnt), 32'(e.cnt));
        chk({tag, "_err"}, 32'(n_err), 32'(e.err));
        chk({tag, "_cov"}, 32'(n_cov), 32'(e.cov));
        chk({tag, "_fv"}, 32'(n_fv), 32'(e.fv));
        chk({tag, "_fvec"}, 32'(n_fvec), 32'(e.fvec));
        chk({tag, "_done"}, 32'(n_done), 32'(e.done));
        chk({tag, "_pass"}, 32'(n_pass), 32'(e.pass));
        chk({tag, "_ready"}, 32'(n_ready), 32'(e.ready));
        chk({tag, "_busy"}, 32'(n_busy), 32'(e.ready));
    endtask

    task automatic cyc(input string tag, input logic rs, input logic st, input logic v,
                       input logic a, input logic b, input logic y);
        rst = rs; start = st; smp_valid = v; smp_a = a; smp_b = b; smp_y = y;
        model_step(rs, st, v, a, b, y);
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; smp_valid = 1'b0;
        sb_check(tag);
    endtask

    task automatic smp(input string tag, input logic a, input logic b, input logic y);
        cyc(tag, 1'b0, 1'b0, 1'b1, a, b, y);
    endtask

    task automatic go(input string tag);
        cyc(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset state
        cyc("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_sat_ready", 32'(s_ready), 32'd0);
        chk("rst_xor_done", 32'(x_done), 32'd0);
        smp("idle_ignored", 1'b0, 1'b0, 1'b1);

        // 1: clean NOR run
        go("t1_start");
        smp("t1_s0", 1'b0, 1'b0, 1'b1);
        smp("t1_s1", 1'b0, 1'b1, 1'b0);
        smp("t1_s2", 1'b1, 1'b0, 1'b0);
        smp("t1_s3", 1'b1, 1'b1, 1'b0);
        chk("t1_pass", 32'(n_pass), 32'd1);
        chk("t1_cnt", 32'(n_cnt), 32'd4);
        smp("t1_done_hold", 1'b0, 1'b0, 1'b0);
        chk("t1_cnt_hold", 32'(n_cnt), 32'd4);

        // 2: two mismatches, first capture kept
        go("t2_start");
        smp("t2_s0", 1'b0, 1'b0, 1'b1);
        smp("t2_s1", 1'b0, 1'b1, 1'b1);
        smp("t2_s2", 1'b1, 1'b0, 1'b1);
        smp("t2_s3", 1'b1, 1'b1, 1'b0);
        chk("t2_err", 32'(n_err), 32'd2);
        chk("t2_fvec", 32'(n_fvec), 32'b011);
        chk("t2_pass", 32'(n_pass), 32'd0);
        chk("t2_done", 32'(n_done), 32'd1);

        // 3: repeated combinations
        go("t3_start");
        for (int i = 0; i < 5; i++) smp("t3_rep", 1'b0, 1'b0, 1'b1);
        smp("t3_s1", 1'b0, 1'b1, 1'b0);
        smp("t3_s2", 1'b1, 1'b0, 1'b0);
        chk("t3_cov_pre", 32'(n_cov), 32'b0111);
        chk("t3_done_pre", 32'(n_done), 32'd0);
        smp("t3_s3", 1'b1, 1'b1, 1'b0);
        chk("t3_cnt", 32'(n_cnt), 32'd8);
        chk("t3_pass", 32'(n_pass), 32'd1);

        // 4: saturation termination on the 3-bit instance
        go("t4_start");
        for (int i = 0; i < 6; i++) smp("t4_rep", 1'b1, 1'b1, 1'b0);
        chk("t4_sat_notdone", 32'(s_done), 32'd0);
        chk("t4_sat_cnt6", 32'(s_cnt), 32'd6);
        smp("t4_last", 1'b1, 1'b1, 1'b0);
        chk("t4_sat_done", 32'(s_done), 32'd1);
        chk("t4_sat_cnt", 32'(s_cnt), 32'd7);
        chk("t4_sat_cov", 32'(s_cov), 32'b1000);
        chk("t4_sat_pass", 32'(s_pass), 32'd0);
        chk("t4_sat_ready", 32'(s_ready), 32'd0);
        smp("t4_sat_extra", 1'b0, 1'b0, 1'b1);
        chk("t4_sat_hold", 32'(s_cnt), 32'd7);

        // 5: restart mid-run with a sample on the start cycle
        go("t5_start");
        smp("t5_s0", 1'b0, 1'b0, 1'b1);
        smp("t5_s1", 1'b0, 1'b1, 1'b1);
        cyc("t5_restart", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_cnt_clr", 32'(n_cnt), 32'd0);
        chk("t5_cov_clr", 32'(n_cov), 32'd0);
        smp("t5_r0", 1'b0, 1'b0, 1'b1);
        smp("t5_r1", 1'b0, 1'b1, 1'b0);
        smp("t5_r2", 1'b1, 1'b0, 1'b0);
        smp("t5_r3", 1'b1, 1'b1, 1'b0);
        chk("t5_pass", 32'(n_pass), 32'd1);

        // 6: reset mid-run, then an XOR run
        go("t6_start");
        smp("t6_s0", 1'b0, 1'b0, 1'b1);
        smp("t6_s1", 1'b0, 1'b1, 1'b0);
        smp("t6_s2", 1'b1, 1'b0, 1'b0);
        cyc("t6_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6_sat_cnt", 32'(s_cnt), 32'd0);
        chk("t6_xor_cov", 32'(x_cov), 32'd0);
        chk("t6_xor_ready", 32'(x_ready), 32'd0);
        smp("t6_ignored", 1'b1, 1'b1, 1'b0);
        chk("t6_xor_ign", 32'(x_cnt), 32'd0);
        go("t6_xor_start");
        smp("t6_x0", 1'b0, 1'b0, 1'b0);
        smp("t6_x1", 1'b0, 1'b1, 1'b1);
        smp("t6_x2", 1'b1, 1'b0, 1'b1);
        smp("t6_x3", 1'b1, 1'b1, 1'b0);
        chk("t6_xor_done", 32'(x_done), 32'd1);
        chk("t6_xor_pass", 32'(x_pass), 32'd1);
        chk("t6_xor_err", 32'(x_err), 32'd0);
        chk("t6_xor_fv", 32'(x_fv), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
